// File: rtl/encoder_mem_responder.sv
// Line-memory responder for the matrix encoder: loads 64 lines from the host, kicks the
// encoder, serves its reads and write-backs in place, then streams the result back out.
module encoder_mem_responder #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             enc_start,
    input  logic [AW-1:0]    enc_addr,
    output logic [WIDTH-1:0] enc_line,
    input  logic             enc_wr_en,
    input  logic [WIDTH-1:0] enc_wr_data,
    input  logic             enc_done,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [AW:0]      wr_count
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_RUN,
        S_DRAIN
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    state_e           state_q, state_d;
    logic [AW-1:0]    ldPtr_q, ldPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      wrCount_q, wrCount_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             memWe;
    logic [AW-1:0]    memAddr;
    logic [WIDTH-1:0] memData;

    // State register; the line array itself is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LOAD;
            ldPtr_q   <= '0;
            rdPtr_q   <= '0;
            wrCount_q <= '0;
        end else begin
            state_q   <= state_d;
            ldPtr_q   <= ldPtr_d;
            rdPtr_q   <= rdPtr_d;
            wrCount_q <= wrCount_d;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem_q[memAddr] <= memData;
        end
    end

    // Next-state logic, including the single shared write port of the array.
    always_comb begin
        state_d   = state_q;
        ldPtr_d   = ldPtr_q;
        rdPtr_d   = rdPtr_q;
        wrCount_d = wrCount_q;
        memWe     = 1'b0;
        memAddr   = ldPtr_q;
        memData   = load_data;
        unique case (state_q)
            S_LOAD: begin
                if (load_valid && !rst) begin
                    memWe   = 1'b1;
                    ldPtr_d = ldPtr_q + AW'(1);
                    if (ldPtr_q == LAST_ADDR) begin
                        ldPtr_d = '0;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                wrCount_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (enc_wr_en && !rst) begin
                    memWe   = 1'b1;
                    memAddr = enc_addr;
                    memData = enc_wr_data;
                    if (wrCount_q != FULL_CNT) begin
                        wrCount_d = wrCount_q + (AW + 1)'(1);
                    end
                end
                if (enc_done) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    rdPtr_d = rdPtr_q + AW'(1);
                    if (rdPtr_q == LAST_ADDR) begin
                        rdPtr_d = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        load_ready = (state_q == S_LOAD) && !rst;
        enc_start  = (state_q == S_START);
        busy       = (state_q == S_START) || (state_q == S_RUN);
        out_valid  = (state_q == S_DRAIN);
        out_last   = (state_q == S_DRAIN) && (rdPtr_q == LAST_ADDR);
        out_data   = mem_q[rdPtr_q];
        enc_line   = mem_q[enc_addr];
        wr_count   = wrCount_q;
    end

endmodule

// File: tb/tb_encoder_mem_responder.sv
// Self-checking bench for encoder_mem_responder: directed passes with randomized data and
// throttling, compared against a line-array reference model held in the bench.
module tb_encoder_mem_responder;

    localparam int WIDTH = 25;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             enc_start;
    logic [AW-1:0]    enc_addr;
    logic [WIDTH-1:0] enc_line;
    logic             enc_wr_en;
    logic [WIDTH-1:0] enc_wr_data;
    logic             enc_done;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             busy;
    logic [AW:0]      wr_count;

    int nCompared   = 0;
    int nMismatched = 0;
    int startPulses = 0;
    int expWrCount  = 0;
    logic [WIDTH-1:0] refMem [DEPTH];

    encoder_mem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .enc_start   (enc_start),
        .enc_addr    (enc_addr),
        .enc_line    (enc_line),
        .enc_wr_en   (enc_wr_en),
        .enc_wr_data (enc_wr_data),
        .enc_done    (enc_done),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (enc_start === 1'b1) startPulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        load_valid  = 1'b0;
        enc_wr_en   = 1'b0;
        enc_done    = 1'b0;
        out_ready   = 1'b0;
        enc_wr_data = '0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        idleInputs();
        @(negedge clk);
        #1;
        checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
        checkOutput("rst_enc_start", 32'(enc_start), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expWrCount = 0;
        #1;
        checkOutput("post_rst_load_ready", 32'(load_ready), 32'd1);
    endtask

    // pattern 0: line i = i*0x1111 masked to 25 bits; pattern 1: random lines
    task automatic applyLoad(input int pattern, input bit throttle, input bit stray);
        int i = 0;
        int budget = 0;
        logic [WIDTH-1:0] val;
        while (i < DEPTH && budget < 2000) begin
            @(negedge clk);
            budget++;
            val = (pattern == 0) ? WIDTH'((i * 32'h1111) & 32'h1FFFFFF) : WIDTH'($urandom);
            load_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            load_data  = val;
            enc_addr   = AW'($urandom);
            if (stray) begin
                enc_wr_en   = 1'($urandom_range(0, 1));
                enc_wr_data = WIDTH'($urandom);
                enc_done    = 1'($urandom_range(0, 1));
            end
            #1;
            if (budget == 1) checkOutput("load_wr_count_hold", 32'(wr_count), 32'(expWrCount));
            if (enc_start !== 1'b0 || load_ready !== 1'b1 || out_valid !== 1'b0) begin
                checkOutput("load_phase_outputs", {29'd0, enc_start, load_ready, out_valid}, 32'b010);
            end
            if (load_valid) begin
                refMem[i] = val;
                i++;
            end
        end
        if (i < DEPTH) checkOutput("load_timeout", 32'(i), 32'(DEPTH));
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("start_pulse", 32'(enc_start), 32'd1);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_load_ready", 32'(load_ready), 32'd0);
    endtask

    // mode 1: write ~line[k] to address k; mode 2: random address and data
    task automatic applyRun(input int mode, input int nWrites, input int nIdle,
                            input bit directed5, input bit doneWith63);
        int total = 0;
        int a;
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("run_enc_start_low", 32'(enc_start), 32'd0);
        checkOutput("run_wr_count_cleared", 32'(wr_count), 32'd0);
        if (directed5) begin
            @(negedge clk);
            enc_addr    = 6'd5;
            enc_wr_en   = 1'b1;
            enc_wr_data = 25'h0ABCDEF;
            #1;
            checkOutput("rdw_old_value", 32'(enc_line), 32'(refMem[5]));
            refMem[5] = 25'h0ABCDEF;
            total++;
            @(negedge clk);
            enc_wr_en = 1'b0;
            #1;
            checkOutput("rdw_new_value", 32'(enc_line), 32'h0ABCDEF);
        end
        for (int k = 0; k < nIdle; k++) begin
            @(negedge clk);
            enc_addr = AW'($urandom);
            #1;
            checkOutput("run_idle_enc_line", 32'(enc_line), 32'(refMem[enc_addr]));
            checkOutput("run_busy", 32'(busy), 32'd1);
        end
        for (int k = 0; k < nWrites; k++) begin
            @(negedge clk);
            a = (mode == 1) ? (k % DEPTH) : int'($urandom_range(0, DEPTH - 1));
            enc_addr    = AW'(a);
            enc_wr_data = (mode == 1) ? ~refMem[a] : WIDTH'($urandom);
            enc_wr_en   = 1'b1;
            #1;
            checkOutput("run_write_enc_line", 32'(enc_line), 32'(refMem[a]));
            refMem[a] = enc_wr_data;
            total++;
        end
        @(negedge clk);
        enc_wr_en = 1'b0;
        if (doneWith63) begin
            enc_addr    = 6'd63;
            enc_wr_data = 25'h1FFFFFF;
            enc_wr_en   = 1'b1;
            refMem[63]  = 25'h1FFFFFF;
            total++;
        end
        enc_done = 1'b1;
        #1;
        checkOutput("done_cycle_busy", 32'(busy), 32'd1);
        checkOutput("done_cycle_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        idleInputs();
        expWrCount = (total > DEPTH) ? DEPTH : total;
        #1;
        checkOutput("drain_entry_out_valid", 32'(out_valid), 32'd1);
        checkOutput("drain_entry_busy", 32'(busy), 32'd0);
        checkOutput("drain_wr_count", 32'(wr_count), 32'(expWrCount));
    endtask

    task automatic applyDrain(input bit throttle, input bit stray, input int abortAt);
        int j = 0;
        int budget = 0;
        while (j < DEPTH && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (j == abortAt) begin
                rst = 1'b1;
                idleInputs();
                #1;
                checkOutput("abort_rst_load_ready", 32'(load_ready), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                expWrCount = 0;
                #1;
                checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
                checkOutput("abort_load_ready", 32'(load_ready), 32'd1);
                checkOutput("abort_wr_count", 32'(wr_count), 32'd0);
                return;
            end
            out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stray) begin
                enc_addr    = AW'($urandom);
                enc_wr_en   = 1'($urandom_range(0, 1));
                enc_wr_data = WIDTH'($urandom);
                enc_done    = 1'($urandom_range(0, 1));
            end
            #1;
            checkOutput("drain_out_valid", 32'(out_valid), 32'd1);
            checkOutput("drain_out_data", 32'(out_data), 32'(refMem[j]));
            checkOutput("drain_out_last", 32'(out_last), 32'(j == DEPTH - 1));
            checkOutput("drain_wr_count_hold", 32'(wr_count), 32'(expWrCount));
            if (out_ready) j++;
        end
        if (j < DEPTH) checkOutput("drain_timeout", 32'(j), 32'(DEPTH));
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("post_drain_load_ready", 32'(load_ready), 32'd1);
        checkOutput("post_drain_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int startsBefore;
        rst         = 1'b1;
        load_data   = '0;
        enc_addr    = '0;
        idleInputs();

        applyReset();

        $display("[TB] pass A: identity load, no encoder writes");
        startsBefore = startPulses;
        applyLoad(0, 1'b0, 1'b0);
        applyRun(0, 0, 4, 1'b0, 1'b0);
        applyDrain(1'b0, 1'b0, -1);
        checkOutput("passA_start_pulses", 32'(startPulses - startsBefore), 32'd1);

        $display("[TB] pass B: encoder inverts every line");
        applyLoad(0, 1'b0, 1'b0);
        applyRun(1, DEPTH, 0, 1'b0, 1'b0);
        applyDrain(1'b0, 1'b0, -1);

        $display("[TB] pass C: throttled, stray strobes, saturation, write with done");
        startsBefore = startPulses;
        applyLoad(1, 1'b1, 1'b1);
        applyRun(2, 70, 3, 1'b1, 1'b1);
        applyDrain(1'b1, 1'b1, -1);
        checkOutput("passC_start_pulses", 32'(startPulses - startsBefore), 32'd1);

        $display("[TB] pass D: reset during drain at line 20");
        applyLoad(1, 1'b0, 1'b0);
        applyRun(2, 10, 2, 1'b0, 1'b0);
        applyDrain(1'b0, 1'b0, 20);

        $display("[TB] pass E: fresh pass after abort");
        startsBefore = startPulses;
        applyLoad(1, 1'b1, 1'b0);
        applyRun(2, 20, 1, 1'b0, 1'b1);
        applyDrain(1'b1, 1'b0, -1);
        checkOutput("passE_start_pulses", 32'(startPulses - startsBefore), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/encoder_mem_responder.md
# encoder_mem_responder

Memory-side responder for the matrix encoder's line interface. Receives a 64-line × 25-bit state from a host stream and pulses the encoder's start. It then serves the encoder's line reads by address and captures its line write-backs in place. Once the encoder signals done, it streams the resulting 64 lines back to the host. It sits between the host/testbench stream and the encoder's `cnt_value`/`line_in`/`write_enable`/`write_value`/`donee` ports.

## Interface
- `WIDTH`, 25, line width in bits (one 5×5 slice)
- `DEPTH`, 64, number of lines
- `AW`, 6, address width, log2(DEPTH)
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `load_valid`  in  1  host presents a line
- `load_data`  in  WIDTH  host line, written in order 0..DEPTH-1
- `load_ready`  out  1  block accepts a line
- `enc_start`  out  1  one-cycle start pulse to encoder
- `enc_addr`  in  AW  encoder line address (its `cnt_value`)
- `enc_line`  out  WIDTH  `mem[enc_addr]`, combinational read (encoder's `line_in`)
- `enc_wr_en`  in  1  encoder write strobe
- `enc_wr_data`  in  WIDTH  encoder write value
- `enc_done`  in  1  encoder finished
- `out_valid`  out  1  result line available
- `out_data`  out  WIDTH  `mem[rd_ptr]`
- `out_last`  out  1  high with line DEPTH-1
- `out_ready`  in  1  host accepts result line
- `busy`  out  1  high in START and RUN
- `wr_count`  out  AW+1  encoder writes captured this pass, saturates at DEPTH

## Operation
- Storage: DEPTH×WIDTH register array. It has one write port (load or encoder write, never both) and combinational reads for `enc_line` and `out_data`. The array is not cleared by reset.
- FSM states: LOAD → START → RUN → DRAIN → LOAD.
- LOAD:
  - `load_ready`=1.
  - On `load_valid && load_ready`: `mem[ld_ptr]<=load_data`, `ld_ptr`++.
  - The handshake at `ld_ptr`=DEPTH-1 moves to START and clears `ld_ptr`.
- START: `enc_start`=1 for exactly one cycle, `wr_count`<=0, then RUN.
- RUN:
  - `enc_wr_en` writes `mem[enc_addr]<=enc_wr_data` and increments `wr_count`, saturating at DEPTH.
  - `enc_done`=1 moves to DRAIN.
  - If `enc_wr_en` and `enc_done` fall in the same cycle, the write is still performed and counted.
- DRAIN:
  - `out_valid`=1; `out_last`=(`rd_ptr`==DEPTH-1).
  - On `out_valid && out_ready`: `rd_ptr`++.
  - The handshake with `out_last` returns to LOAD and clears `rd_ptr`.
  - `out_data` holds stable while `out_ready`=0.
- Ignored inputs:
  - `enc_wr_en`/`enc_done` are ignored outside RUN.
  - `load_valid` is ignored outside LOAD.
  - `out_ready` is ignored outside DRAIN.
- `enc_line` is valid in every state. Read-during-write returns the old value; the new value is visible the cycle after the edge.
- `wr_count` holds its value through DRAIN and LOAD until the next START.

## Timing
- Reset:
  - state=LOAD; `ld_ptr`=`rd_ptr`=0; `wr_count`=0.
  - `enc_start`=0, `out_valid`=0, `out_last`=0, `busy`=0.
  - `load_ready`=1 from the first cycle after `rst` deasserts; it is 0 while `rst`=1.
- Reset mid-operation (any state) aborts the pass; the next pass starts at LOAD with `ld_ptr`=0.
- Load: one line per cycle when `load_valid` is held. With continuous valid, `enc_start` is high in the cycle after the 64th handshake.
- Encoder: `busy`=1 from the START cycle through the `enc_done` cycle. DRAIN (`out_valid`=1) begins the cycle after `enc_done`.
- Drain: one line per cycle with `out_ready` held; 64 cycles minimum. `load_ready`=1 in the cycle after the `out_last` handshake.
- `enc_start` is a registered state decode: exactly one cycle high per pass, never two consecutive cycles.

## Test plan
- Load `line i = i*0x1111 & 0x1FFFFFF` (i=0..63), no encoder writes, `enc_done` 5 cycles after start → `out_data` returns identical 64 lines, `out_last` only on line 63, `wr_count`=0.
- Same load; during RUN, write `mem[a] = ~load[a]` for a=0..63, then `enc_done` → drained line a = `~load[a]` (25-bit), `wr_count`=64.
- Write to addr 5 value 0x0ABCDEF while sampling `enc_addr`=5 → `enc_line` shows old value that cycle and 0x0ABCDEF the next cycle.
- `enc_wr_en`(addr 63, 0x1FFFFFF) in the same cycle as `enc_done` → line 63 drains as 0x1FFFFFF; stray `enc_wr_en`/`enc_done` during LOAD/DRAIN have no effect.
- Random `load_valid`/`out_ready` throttling (50%) → no lost or duplicated lines; `out_data` stable while stalled; exactly one `enc_start` pulse.
- Assert `rst` mid-DRAIN at line 20 → next cycle `out_valid`=0, `load_ready`=1; a fresh pass completes correctly from line 0.
